// File: rtl/gate_seq_ctrl.sv
// ---------------------------------------------------------------------------
// gate_seq_ctrl
//
// Steps a single gate/delay pulse generator through a programmable table of
// (delay, width) entries. Software arms a run. The first step fires on a
// rising edge of the external trigger. Later steps fire either on further
// trigger edges (gated mode) or straight after the previous pulse completes
// (chain mode).
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_cfg_we/addr      table write strobe and entry address (honoured in IDLE only)
//   i_cfg_delay/width  entry contents
//   i_num_steps        steps per run (1..DEPTH), sampled on arm
//   i_chain            1 = back-to-back steps, 0 = one trigger edge per step
//   i_arm              start a run (level, acted on in IDLE)
//   i_abort            terminate the run, return to IDLE
//   i_ext_trigger      external trigger, already in the i_clk domain
//   i_gen_busy         generator busy
//   o_gen_trigger      trigger to generator, held until busy is seen
//   o_gen_delay/width  parameters for the current step
//   o_step             current step index
//   o_armed            waiting for a trigger edge
//   o_running          sequencer not IDLE
//   o_done             one-cycle pulse when the last step completes
//   o_err              sticky error (bad arm, dropped write, busy timeout)
// ---------------------------------------------------------------------------
module gate_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int TMO   = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cfg_we,
  input  logic [AW-1:0] i_cfg_addr,
  input  logic [31:0]   i_cfg_delay,
  input  logic [31:0]   i_cfg_width,
  input  logic [AW:0]   i_num_steps,
  input  logic          i_chain,
  input  logic          i_arm,
  input  logic          i_abort,
  input  logic          i_ext_trigger,
  input  logic          i_gen_busy,
  output logic          o_gen_trigger,
  output logic [31:0]   o_gen_delay,
  output logic [31:0]   o_gen_width,
  output logic [AW-1:0] o_step,
  output logic          o_armed,
  output logic          o_running,
  output logic          o_done,
  output logic          o_err
);

  localparam int            TW       = $clog2(TMO + 1);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_STEP = (AW+1)'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
  localparam logic [TW-1:0] TMO_SAT  = TW'(TMO);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARMED,
    S_START,
    S_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   step_q, step_d;
  logic [AW:0]   num_steps_q, num_steps_d;
  logic          chain_q, chain_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          trig_q, trig_d;
  logic          armed_q, armed_d;
  logic          running_q, running_d;
  logic [31:0]   delay_q, delay_d;
  logic [31:0]   width_q, width_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_last_q;

  // Table: {delay, width} per entry, not reset.
  logic [63:0]   cfg_mem [DEPTH];

  logic          ext_edge;
  logic          cfg_wr_ok;
  logic          wr_drop;
  logic          arm_ok;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_raw;
  logic [63:0]   rd_data;

  assign ext_edge  = i_ext_trigger & ~ext_last_q;
  assign cfg_wr_ok = i_cfg_we & (state_q == S_IDLE);
  assign wr_drop   = i_cfg_we & (state_q != S_IDLE);
  assign arm_ok    = (i_num_steps != '0) && (i_num_steps <= DEPTH_L);

  // ---------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (cfg_wr_ok) begin
      cfg_mem[i_cfg_addr] <= {i_cfg_delay, i_cfg_width};
    end
  end

  // The entry is fetched on the edge that enters LOAD, so the generator
  // parameters are already on the outputs during the LOAD cycle, one cycle
  // ahead of the trigger. A write landing in the same cycle as the arm is
  // forwarded so the run sees the new entry.
  assign rd_addr = step_d[AW-1:0];
  assign rd_raw  = cfg_mem[rd_addr];
  assign rd_data = (cfg_wr_ok && (i_cfg_addr == rd_addr))
                 ? {i_cfg_delay, i_cfg_width} : rd_raw;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    num_steps_d = num_steps_q;
    chain_d     = chain_q;
    err_d       = err_q | wr_drop;
    done_d      = 1'b0;
    tmo_d       = tmo_q;

    if (i_abort) begin
      // Abort wins over everything, including a simultaneous arm.
      state_d = S_IDLE;
      step_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_arm) begin
            if (arm_ok) begin
              num_steps_d = i_num_steps;
              chain_d     = i_chain;
              err_d       = 1'b0;
              step_d      = '0;
              state_d     = S_LOAD;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        S_LOAD: begin
          tmo_d = '0;
          // The first step always waits for an edge; chain mode skips the
          // wait for every later step.
          if ((step_q == '0) || !chain_q) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_START;
          end
        end

        S_ARMED: begin
          tmo_d = '0;
          if (ext_edge) begin
            state_d = S_START;
          end
        end

        S_START: begin
          if (i_gen_busy) begin
            state_d = S_RUN;
          end else if (tmo_q >= TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            step_d  = '0;
          end else if (tmo_q != TMO_SAT) begin
            tmo_d = tmo_q + TW'(1);
          end
        end

        S_RUN: begin
          if (!i_gen_busy) begin
            if (step_q == (num_steps_q - ONE_STEP)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
              step_d  = '0;
            end else begin
              step_d  = step_q + ONE_STEP;
              state_d = S_LOAD;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          step_d  = '0;
        end
      endcase
    end
  end

  // Registered outputs are derived from the next state so that they line up
  // with the state they describe.
  always_comb begin
    trig_d    = (state_d == S_START);
    armed_d   = (state_d == S_ARMED);
    running_d = (state_d != S_IDLE);
    delay_d   = delay_q;
    width_d   = width_q;
    if (state_d == S_LOAD) begin
      delay_d = rd_data[63:32];
      width_d = rd_data[31:0];
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      num_steps_q <= '0;
      chain_q     <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      trig_q      <= 1'b0;
      armed_q     <= 1'b0;
      running_q   <= 1'b0;
      delay_q     <= '0;
      width_q     <= '0;
      tmo_q       <= '0;
      ext_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      num_steps_q <= num_steps_d;
      chain_q     <= chain_d;
      err_q       <= err_d;
      done_q      <= done_d;
      trig_q      <= trig_d;
      armed_q     <= armed_d;
      running_q   <= running_d;
      delay_q     <= delay_d;
      width_q     <= width_d;
      tmo_q       <= tmo_d;
      ext_last_q  <= i_ext_trigger;
    end
  end

  assign o_gen_trigger = trig_q;
  assign o_gen_delay   = delay_q;
  assign o_gen_width   = width_q;
  assign o_step        = step_q[AW-1:0];
  assign o_armed       = armed_q;
  assign o_running     = running_q;
  assign o_done        = done_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gate_seq_ctrl
//
// Directed bench for gate_seq_ctrl. A small generator model answers each
// trigger with busy after GEN_LAT cycles and holds busy for BUSY_LEN cycles.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_gate_seq_ctrl;

  localparam int DEPTH    = 8;
  localparam int AW       = 3;
  localparam int TMO      = 16;
  localparam int GEN_LAT  = 2;
  localparam int BUSY_LEN = 3;

  logic          i_clk;
  logic          i_rst;
  logic          i_cfg_we;
  logic [AW-1:0] i_cfg_addr;
  logic [31:0]   i_cfg_delay;
  logic [31:0]   i_cfg_width;
  logic [AW:0]   i_num_steps;
  logic          i_chain;
  logic          i_arm;
  logic          i_abort;
  logic          i_ext_trigger;
  logic          i_gen_busy;
  logic          o_gen_trigger;
  logic [31:0]   o_gen_delay;
  logic [31:0]   o_gen_width;
  logic [AW-1:0] o_step;
  logic          o_armed;
  logic          o_running;
  logic          o_done;
  logic          o_err;

  gate_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .TMO(TMO)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_addr    (i_cfg_addr),
    .i_cfg_delay   (i_cfg_delay),
    .i_cfg_width   (i_cfg_width),
    .i_num_steps   (i_num_steps),
    .i_chain       (i_chain),
    .i_arm         (i_arm),
    .i_abort       (i_abort),
    .i_ext_trigger (i_ext_trigger),
    .i_gen_busy    (i_gen_busy),
    .o_gen_trigger (o_gen_trigger),
    .o_gen_delay   (o_gen_delay),
    .o_gen_width   (o_gen_width),
    .o_step        (o_step),
    .o_armed       (o_armed),
    .o_running     (o_running),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cycle        = 0;
  int          trig_rises   = 0;
  int          trig_cycles  = 0;
  int          done_cnt     = 0;
  int          armed_cnt    = 0;
  int          stale_cnt    = 0;
  int          busy_fall_cycle = 0;
  int          lat_cnt      = 0;
  int          busy_cnt     = 0;
  bit          gen_en       = 1'b1;
  logic        trig_last    = 1'b0;
  logic [31:0] prev_delay   = '0;
  logic [31:0] prev_width   = '0;
  logic [31:0] seen_delay [8];
  logic [31:0] seen_width [8];
  int          gap [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    trig_rises  = 0;
    trig_cycles = 0;
    done_cnt    = 0;
    armed_cnt   = 0;
    stale_cnt   = 0;
    for (int i = 0; i < 8; i++) begin
      seen_delay[i] = '0;
      seen_width[i] = '0;
      gap[i]        = 0;
    end
  endtask

  // One clock: observe outputs, then let the generator model react.
  task automatic tick();
    @(posedge i_clk);
    #1;
    cycle++;
    if (o_gen_trigger) trig_cycles++;
    if (o_done) done_cnt++;
    if (o_armed) armed_cnt++;
    if (o_gen_trigger && !trig_last) begin
      if (trig_rises < 8) begin
        seen_delay[trig_rises] = o_gen_delay;
        seen_width[trig_rises] = o_gen_width;
        gap[trig_rises]        = cycle - busy_fall_cycle;
      end
      if ((prev_delay !== o_gen_delay) || (prev_width !== o_gen_width)) stale_cnt++;
      trig_rises++;
    end
    trig_last  = o_gen_trigger;
    prev_delay = o_gen_delay;
    prev_width = o_gen_width;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        i_gen_busy      = 1'b0;
        busy_fall_cycle = cycle;
      end
    end else if (gen_en && o_gen_trigger && !i_gen_busy) begin
      if (lat_cnt == GEN_LAT) begin
        i_gen_busy = 1'b1;
        busy_cnt   = BUSY_LEN;
        lat_cnt    = 0;
      end else begin
        lat_cnt++;
      end
    end
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] w);
    i_cfg_we    = 1'b1;
    i_cfg_addr  = a;
    i_cfg_delay = d;
    i_cfg_width = w;
    tick();
    i_cfg_we    = 1'b0;
  endtask

  task automatic arm(input logic [AW:0] n, input logic ch);
    i_num_steps = n;
    i_chain     = ch;
    i_arm       = 1'b1;
    tick();
    i_arm       = 1'b0;
  endtask

  task automatic abort_run();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
  endtask

  task automatic pulse_ext();
    i_ext_trigger = 1'b1;
    tick();
    i_ext_trigger = 1'b0;
    tick();
  endtask

  task automatic wait_armed(input string tag);
    int n = 0;
    while (!o_armed && n < 60) begin
      tick();
      n++;
    end
    chk(tag, o_armed, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_running && n < 200) begin
      tick();
      n++;
    end
    chk(tag, o_running, 0);
  endtask

  initial begin
    i_rst         = 1'b1;
    i_cfg_we      = 1'b0;
    i_cfg_addr    = '0;
    i_cfg_delay   = '0;
    i_cfg_width   = '0;
    i_num_steps   = '0;
    i_chain       = 1'b0;
    i_arm         = 1'b0;
    i_abort       = 1'b0;
    i_ext_trigger = 1'b0;
    i_gen_busy    = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;

    // Reset state
    chk("rst_running", o_running, 0);
    chk("rst_trigger", o_gen_trigger, 0);
    chk("rst_delay", o_gen_delay, 0);
    chk("rst_width", o_gen_width, 0);
    chk("rst_step", o_step, 0);
    chk("rst_armed", o_armed, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);

    // Gated mode, 3 steps, one edge per step
    cfg_write(0, 10, 5);
    cfg_write(1, 20, 5);
    cfg_write(2, 30, 5);
    clear_stats();
    arm(3, 1'b0);
    chk("g_load_running", o_running, 1);
    chk("g_load_delay", o_gen_delay, 10);
    for (int s = 0; s < 3; s++) begin
      wait_armed("g_armed");
      chk("g_step", o_step, s);
      chk("g_delay", o_gen_delay, 10 * (s + 1));
      chk("g_width", o_gen_width, 5);
      pulse_ext();
    end
    wait_idle("g_idle");
    chk("g_rises", trig_rises, 3);
    chk("g_trig_cycles", trig_cycles, 3 * (GEN_LAT + 1));
    chk("g_done", done_cnt, 1);
    chk("g_seen_d2", seen_delay[2], 30);
    chk("g_stale", stale_cnt, 0);
    chk("g_step_idle", o_step, 0);
    chk("g_err", o_err, 0);

    // Chain mode: one edge runs all three steps
    clear_stats();
    arm(3, 1'b1);
    wait_armed("c_armed");
    armed_cnt = 0;
    pulse_ext();
    wait_idle("c_idle");
    chk("c_rises", trig_rises, 3);
    chk("c_done", done_cnt, 1);
    chk("c_seen_d0", seen_delay[0], 10);
    chk("c_seen_d1", seen_delay[1], 20);
    chk("c_seen_d2", seen_delay[2], 30);
    chk("c_seen_w2", seen_width[2], 5);
    chk("c_gap1", gap[1], 2);
    chk("c_gap2", gap[2], 2);
    chk("c_no_rearm", armed_cnt, 0);
    chk("c_stale", stale_cnt, 0);

    // Busy timeout
    clear_stats();
    gen_en = 1'b0;
    arm(1, 1'b0);
    wait_armed("t_armed");
    pulse_ext();
    wait_idle("t_idle");
    chk("t_trig_cycles", trig_cycles, TMO);
    chk("t_err", o_err, 1);
    chk("t_done", done_cnt, 0);
    chk("t_trigger_low", o_gen_trigger, 0);
    gen_en = 1'b1;
    arm(1, 1'b0);
    chk("t_rearm_err", o_err, 0);
    abort_run();

    // Abort during RUN of step 1
    clear_stats();
    arm(3, 1'b0);
    wait_armed("a_armed0");
    pulse_ext();
    wait_armed("a_armed1");
    pulse_ext();
    for (int n = 0; n < 20 && !(i_gen_busy && !o_gen_trigger); n++) tick();
    chk("a_in_run", i_gen_busy && !o_gen_trigger, 1);
    chk("a_step", o_step, 1);
    abort_run();
    chk("a_running", o_running, 0);
    chk("a_trigger", o_gen_trigger, 0);
    chk("a_step_idle", o_step, 0);
    repeat (6) tick();
    chk("a_done", done_cnt, 0);
    chk("a_err", o_err, 0);
    arm(3, 1'b0);
    wait_armed("a_rearm");
    chk("a_rearm_step", o_step, 0);
    chk("a_rearm_delay", o_gen_delay, 10);
    abort_run();

    // Write while ARMED is dropped; zero and oversize step counts rejected
    arm(1, 1'b0);
    wait_armed("w_armed");
    cfg_write(0, 99, 99);
    chk("w_err", o_err, 1);
    abort_run();
    chk("w_err_after_abort", o_err, 1);
    arm(0, 1'b0);
    chk("w_zero_idle", o_running, 0);
    chk("w_zero_err", o_err, 1);
    arm(9, 1'b0);
    chk("w_big_idle", o_running, 0);
    chk("w_big_err", o_err, 1);
    arm(1, 1'b0);
    chk("w_table_delay", o_gen_delay, 10);
    chk("w_table_width", o_gen_width, 5);
    chk("w_err_cleared", o_err, 0);
    abort_run();

    // Extra edges during START/RUN are ignored, no queuing
    clear_stats();
    arm(2, 1'b0);
    wait_armed("e_armed0");
    pulse_ext();
    pulse_ext();
    pulse_ext();
    wait_armed("e_armed1");
    repeat (5) tick();
    chk("e_still_armed", o_armed, 1);
    chk("e_rises_mid", trig_rises, 1);
    chk("e_step", o_step, 1);
    pulse_ext();
    wait_idle("e_idle");
    chk("e_rises", trig_rises, 2);
    chk("e_done", done_cnt, 1);

    // Write and arm together in IDLE: run uses the new entry
    i_cfg_we    = 1'b1;
    i_cfg_addr  = 0;
    i_cfg_delay = 77;
    i_cfg_width = 7;
    arm(1, 1'b0);
    i_cfg_we    = 1'b0;
    chk("f_delay", o_gen_delay, 77);
    chk("f_width", o_gen_width, 7);
    chk("f_err", o_err, 0);

    // Reset mid-run clears the sticky error
    wait_armed("r_armed");
    cfg_write(1, 1, 1);
    chk("r_err_set", o_err, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("r_err", o_err, 0);
    chk("r_running", o_running, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
